booth_mac_sequencer: RTL and testbench

- Upstream/downstream control stage wrapped around the 64-bit signed Booth multiplier.
- Accepts a stream of signed operand pairs over valid/ready and issues each pair to the multiplier with a one-cycle start pulse.
- Captures each product on done and accumulates it into a guard-bit-extended accumulator.
- Presents the dot-product result over valid/ready when the pair tagged last completes.

---
 rtl/booth_mac_sequencer.sv | 138 +++++++++++++
 tb/tb_booth_mac_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_sequencer.sv
// Valid/ready control stage around a signed Booth multiplier: issues operand pairs,
// accumulates products into a guard-extended accumulator. Define MAC_SAT_EN to clamp on overflow.
module booth_mac_sequencer #(
    parameter int N     = 64,
    parameter int G     = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_a,
    input  logic [N-1:0]       in_b,
    input  logic               in_last,
    output logic               mul_start,
    output logic [N-1:0]       mul_multiplicand,
    output logic [N-1:0]       mul_multiplier,
    input  logic [2*N-1:0]     mul_product,
    input  logic               mul_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N+G-1:0]   out_acc,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf
);

    localparam int ACC_W = 2*N + G;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, OUT} state_e;

    state_e                    state_q, state_d;
    logic [N-1:0]              a_q, b_q;
    logic                      last_q;
    logic                      done_q;
    logic signed [2*N-1:0]     prod_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      ovf_q, ovf_d;

    logic                      accept;
    logic                      completion;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum;
    logic                      add_ovf;

    assign accept     = in_valid && in_ready;
    // done may be left high by the previous operation, so only a rising edge counts
    assign completion = mul_done && !done_q;

    always_comb begin
        prod_ext = ACC_W'(prod_q);
        sum      = acc_q + prod_ext;
        add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_d = ISSUE;
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (completion) state_d = ACCUM;
            end
            ACCUM: begin
                state_d = last_q ? OUT : IDLE;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (state_q == ACCUM) begin
            acc_d = sum;
`ifdef MAC_SAT_EN
            if (add_ovf) acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
            ovf_d   = ovf_q || add_ovf;
            count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
        end else if (state_q == OUT && out_ready) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments and the async reset clears every one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= mul_done;
            if (accept) begin
                a_q    <= in_a;
                b_q    <= in_b;
                last_q <= in_last;
            end
            if (state_q == WAIT && completion) prod_q <= mul_product;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign out_acc          = acc_q;
    assign out_count        = count_q;
    assign out_ovf          = ovf_q;

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Bench for booth_mac_sequencer: a 64-bit instance driven from a vector table with a
// scoreboard, plus an 8-bit/G=0 instance for the overflow case.
module tb_booth_mac_sequencer;

    localparam int L = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 64-bit instance
    logic                 in_valid, in_ready, in_last;
    logic signed [63:0]   in_a, in_b;
    logic                 mul_start, mul_done;
    logic [63:0]          mul_a, mul_b;
    logic signed [127:0]  mul_product;
    logic                 out_valid, out_ready, out_ovf;
    logic [135:0]         out_acc;
    logic [15:0]          out_count;

    booth_mac_sequencer #(.N(64), .G(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mul_start(mul_start), .mul_multiplicand(mul_a), .mul_multiplier(mul_b),
        .mul_product(mul_product), .mul_done(mul_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    // 8-bit, no guard bits
    logic                 in8_valid, in8_ready, in8_last;
    logic signed [7:0]    in8_a, in8_b;
    logic                 mul8_start, mul8_done;
    logic [7:0]           mul8_a, mul8_b;
    logic signed [15:0]   mul8_product;
    logic                 out8_valid, out8_ovf;
    logic                 out8_ready = 1'b1;
    logic [15:0]          out8_acc;
    logic [15:0]          out8_count;

    booth_mac_sequencer #(.N(8), .G(0), .CNT_W(16)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in8_valid), .in_ready(in8_ready), .in_a(in8_a), .in_b(in8_b), .in_last(in8_last),
        .mul_start(mul8_start), .mul_multiplicand(mul8_a), .mul_multiplier(mul8_b),
        .mul_product(mul8_product), .mul_done(mul8_done),
        .out_valid(out8_valid), .out_ready(out8_ready),
        .out_acc(out8_acc), .out_count(out8_count), .out_ovf(out8_ovf)
    );

    // Multiplier models: done stays high after completion, drops one cycle after start,
    // and rises L cycles after start; product is garbage until then.
    logic               mbusy, m8busy;
    logic [2:0]         mcnt, m8cnt;
    logic signed [63:0] ma, mb;
    logic signed [7:0]  m8a, m8b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done <= 1'b0; mbusy <= 1'b0; mcnt <= '0; mul_product <= '0; ma <= '0; mb <= '0;
        end else if (mul_start) begin
            ma <= mul_a; mb <= mul_b; mbusy <= 1'b1; mcnt <= '0;
            mul_product <= {8{16'hDEAD}};
        end else if (mbusy) begin
            mcnt <= mcnt + 3'd1;
            if (mcnt == 3'd0) mul_done <= 1'b0;
            if (mcnt == 3'(L-1)) begin
                mul_done <= 1'b1; mbusy <= 1'b0;
                mul_product <= 128'(ma) * 128'(mb);
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul8_done <= 1'b0; m8busy <= 1'b0; m8cnt <= '0; mul8_product <= '0; m8a <= '0; m8b <= '0;
        end else if (mul8_start) begin
            m8a <= mul8_a; m8b <= mul8_b; m8busy <= 1'b1; m8cnt <= '0;
            mul8_product <= 16'hA5C3;
        end else if (m8busy) begin
            m8cnt <= m8cnt + 3'd1;
            if (m8cnt == 3'd0) mul8_done <= 1'b0;
            if (m8cnt == 3'(L-1)) begin
                mul8_done <= 1'b1; m8busy <= 1'b0;
                mul8_product <= 16'(m8a) * 16'(m8b);
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int sent = 0;
    int start_cnt = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && mul_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [135:0] acc;
        logic [15:0]  cnt;
        logic         ovf;
    } exp_t;
    exp_t sb[$];

    // Scoreboard: compare each accepted result against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && !ov_prev) check("latency", 136'(cyc - acc_cyc), 136'(3 + L));
        ov_prev = out_valid;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out: got acc %h with no expected result", out_acc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_acc", out_acc, e.acc);
                check("out_count", 136'(out_count), 136'(e.cnt));
                check("out_ovf", 136'(out_ovf), 136'(e.ovf));
            end
        end
    end

    task automatic push_exp(input logic signed [135:0] acc, input logic [15:0] cnt);
        exp_t e;
        e.acc = acc; e.cnt = cnt; e.ovf = 1'b0;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns two negedges after the accept edge (state WAIT).
    task automatic send_pair(input logic signed [63:0] a, input logic signed [63:0] b, input logic l);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("in_ready_timeout", 136'(in_ready), 136'(1));
        in_valid = 1'b1; in_a = a; in_b = b; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc = cyc;
        sent++;
        @(negedge clk);
        check("start_pulse", 136'(mul_start), 136'(1));
        check("in_ready_issue", 136'(in_ready), 136'(0));
        @(negedge clk);
        check("start_single", 136'(mul_start), 136'(0));
        check("in_ready_wait", 136'(in_ready), 136'(0));
        @(posedge clk); #1;
    endtask

    task automatic send8(input logic signed [7:0] a, input logic signed [7:0] b, input logic l);
        int n = 0;
        while (!in8_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!in8_ready) check("in8_ready_timeout", 136'(in8_ready), 136'(1));
        in8_valid = 1'b1; in8_a = a; in8_b = b; in8_last = l;
        @(posedge clk); #1;
        in8_valid = 1'b0;
    endtask

    typedef struct {
        logic signed [63:0]  a;
        logic signed [63:0]  b;
        logic                last;
        logic signed [135:0] exp_acc;
        logic [15:0]         exp_cnt;
    } vec_t;

`ifdef MAC_SAT_EN
    localparam logic [15:0] EXP8 = 16'h7FFF;
`else
    localparam logic [15:0] EXP8 = 16'hBD03;
`endif

    initial begin
        vec_t vecs [9];
        logic signed [63:0]  smin, smax;
        logic signed [135:0] big, mix;
        int n;

        smin = 64'sh8000_0000_0000_0000;
        smax = 64'sh7FFF_FFFF_FFFF_FFFF;
        big  = 136'sd1;
        big  = big <<< 126;
        mix  = 136'sd1;
        mix  = -(mix <<< 63) + 136'sd1;
        vecs[0] = '{64'sd3,    64'sd5,     1'b1, 136'sd15,   16'd1};
        vecs[1] = '{-64'sd2,   64'sd7,     1'b0, 136'sd0,    16'd0};
        vecs[2] = '{64'sd4,    64'sd4,     1'b0, 136'sd0,    16'd0};
        vecs[3] = '{-64'sd1,   -64'sd1,    1'b1, 136'sd3,    16'd3};
        vecs[4] = '{64'sd0,    64'sd12345, 1'b0, 136'sd0,    16'd0};
        vecs[5] = '{-64'sd100, 64'sd3,     1'b1, -136'sd300, 16'd2};
        vecs[6] = '{smin,      smin,       1'b1, big,        16'd1};
        vecs[7] = '{smin,      smax,       1'b0, 136'sd0,    16'd0};
        vecs[8] = '{smax,      smax,       1'b1, mix,        16'd2};

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        in8_valid = 1'b0; in8_a = '0; in8_b = '0; in8_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 136'(in_ready), 136'(0));
        check("rst_out_valid", 136'(out_valid), 136'(0));
        check("rst_out_acc", out_acc, 136'(0));
        check("rst_out_count", 136'(out_count), 136'(0));
        check("rst_mul_start", 136'(mul_start), 136'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", 136'(in_ready), 136'(1));

        // Table-driven groups
        for (int i = 0; i < 9; i++) begin
            send_pair(vecs[i].a, vecs[i].b, vecs[i].last);
            if (vecs[i].last) push_exp(vecs[i].exp_acc, vecs[i].exp_cnt);
        end

        // Backpressure in OUT
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_pair(64'sd10, -64'sd3, 1'b1);
        push_exp(-136'sd30, 16'd1);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        check("stall_reached_out", 136'(out_valid), 136'(1));
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 64'sd2; in_b = 64'sd2; in_last = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_valid", 136'(out_valid), 136'(1));
            check("stall_acc", out_acc, -136'sd30);
            check("stall_count", 136'(out_count), 136'(1));
            check("stall_in_ready", 136'(in_ready), 136'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_valid_drop", 136'(out_valid), 136'(0));
        check("release_in_ready", 136'(in_ready), 136'(1));
        @(posedge clk); #1;
        send_pair(64'sd2, 64'sd2, 1'b1);
        push_exp(136'sd4, 16'd1);
        n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end

        // Reset during WAIT with a partial accumulation pending
        @(posedge clk); #1;
        send_pair(64'sd5, 64'sd5, 1'b0);
        send_pair(64'sd9, 64'sd9, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 136'(in_ready), 136'(0));
        check("mid_rst_start", 136'(mul_start), 136'(0));
        check("mid_rst_mcand", 136'(mul_a), 136'(0));
        check("mid_rst_mplier", 136'(mul_b), 136'(0));
        check("mid_rst_valid", 136'(out_valid), 136'(0));
        check("mid_rst_acc", out_acc, 136'(0));
        check("mid_rst_count", 136'(out_count), 136'(0));
        check("mid_rst_ovf", 136'(out_ovf), 136'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send_pair(64'sd6, 64'sd7, 1'b1);
        push_exp(136'sd42, 16'd1);

        // 8-bit, G=0 overflow
        for (int k = 0; k < 3; k++) send8(8'sd127, 8'sd127, k == 2);
        n = 0;
        while (!out8_valid && n < 100) begin @(negedge clk); n++; end
        check("ovf8_valid", 136'(out8_valid), 136'(1));
        check("ovf8_acc", 136'(out8_acc), 136'(EXP8));
        check("ovf8_count", 136'(out8_count), 136'(3));
        check("ovf8_flag", 136'(out8_ovf), 136'(1));

        n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
        check("sb_drain", 136'(sb.size()), 136'(0));
        check("start_pulses", 136'(start_cnt), 136'(sent));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
